// File: rtl/pixel_array_2x2.sv
// Behavioural 2x2 image-sensor pixel array: light integration, single-slope ADC, tristate readout.
// Optional PIXEL_SAT_EN: charge and ramp saturate instead of wrapping.
module pixel_array_2x2 #(
    parameter logic [7:0] LIGHT0 = 8'd64,
    parameter logic [7:0] LIGHT1 = 8'd128,
    parameter logic [7:0] LIGHT2 = 8'd192,
    parameter logic [7:0] LIGHT3 = 8'd255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       anaBias,
    input  logic       anaRamp,
    input  logic       erase,
    input  logic       expose,
    input  logic       read,
    inout  wire  [7:0] pixData1,
    inout  wire  [7:0] pixData2,
    inout  wire  [7:0] pixData3,
    inout  wire  [7:0] pixData4
);

    logic [15:0] chg     [4];
    logic [7:0]  ramp    [4];
    logic        cmp     [4];
    logic [7:0]  pdat    [4];
    logic [7:0]  light   [4];
    logic [7:0]  bus_in  [4];
    logic [15:0] chg_sum [4];
    logic [7:0]  ramp_inc[4];

    assign light[0] = LIGHT0;
    assign light[1] = LIGHT1;
    assign light[2] = LIGHT2;
    assign light[3] = LIGHT3;

    assign bus_in[0] = pixData1;
    assign bus_in[1] = pixData2;
    assign bus_in[2] = pixData3;
    assign bus_in[3] = pixData4;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
`ifdef PIXEL_SAT_EN
            chg_sum[k]  = (chg[k] > (16'hFFFF - {8'h00, light[k]})) ? 16'hFFFF
                                                                   : chg[k] + {8'h00, light[k]};
            ramp_inc[k] = (ramp[k] == 8'hFF) ? 8'hFF : ramp[k] + 8'd1;
`else
            chg_sum[k]  = chg[k] + {8'h00, light[k]};
            ramp_inc[k] = ramp[k] + 8'd1;
`endif
        end
    end

    // Once the ramp passes the stored charge the comparator stays tripped until erase.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (reset) begin
                chg[k]  <= 16'h0000;
                ramp[k] <= 8'h00;
                cmp[k]  <= 1'b0;
                pdat[k] <= 8'h00;
            end else if (erase) begin
                chg[k]  <= 16'h0000;
                ramp[k] <= 8'h00;
                cmp[k]  <= 1'b0;
            end else if (expose) begin
                if (anaBias) chg[k] <= chg_sum[k];
            end else if (anaRamp && !read && !cmp[k]) begin
                pdat[k] <= bus_in[k];
                ramp[k] <= ramp_inc[k];
                cmp[k]  <= (ramp_inc[k] > chg[k][15:8]);
            end
        end
    end

    assign pixData1 = read ? pdat[0] : 8'bz;
    assign pixData2 = read ? pdat[1] : 8'bz;
    assign pixData3 = read ? pdat[2] : 8'bz;
    assign pixData4 = read ? pdat[3] : 8'bz;

endmodule

// File: tb/tb_pixel_array_2x2.sv
// Bench for pixel_array_2x2: directed scenarios plus randomized expose/convert trials
// against an arithmetic reference model (honours PIXEL_SAT_EN).
module tb_pixel_array_2x2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       anaBias = 1'b0;
    logic       anaRamp = 1'b0;
    logic       erase = 1'b0;
    logic       expose = 1'b0;
    logic       read = 1'b0;
    logic       drv_en = 1'b1;
    logic [7:0] drv [4];
    wire  [7:0] pixData1, pixData2, pixData3, pixData4;
    wire  [7:0] bus_w [4];

    int checks = 0;
    int passed = 0;

    // reference model: charge as plain integers, pdat, trip flag, steps since erase
    int light_tb [4] = '{64, 128, 192, 255};
    int m_chg [4];
    int m_pdat[4];
    bit m_trip[4];
    int m_steps;

    assign pixData1 = drv_en ? drv[0] : 8'bz;
    assign pixData2 = drv_en ? drv[1] : 8'bz;
    assign pixData3 = drv_en ? drv[2] : 8'bz;
    assign pixData4 = drv_en ? drv[3] : 8'bz;
    assign bus_w[0] = pixData1;
    assign bus_w[1] = pixData2;
    assign bus_w[2] = pixData3;
    assign bus_w[3] = pixData4;

    pixel_array_2x2 dut (
        .clk(clk), .reset(reset), .anaBias(anaBias), .anaRamp(anaRamp),
        .erase(erase), .expose(expose), .read(read),
        .pixData1(pixData1), .pixData2(pixData2), .pixData3(pixData3), .pixData4(pixData4)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic void m_clear_all();
        for (int k = 0; k < 4; k++) begin
            m_chg[k] = 0; m_pdat[k] = 0; m_trip[k] = 1'b0;
        end
        m_steps = 0;
    endfunction

    function automatic void m_expose_cycle();
        for (int k = 0; k < 4; k++) begin
`ifdef PIXEL_SAT_EN
            m_chg[k] = (m_chg[k] + light_tb[k] > 65535) ? 65535 : m_chg[k] + light_tb[k];
`else
            m_chg[k] = (m_chg[k] + light_tb[k]) % 65536;
`endif
        end
    endfunction

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) tick();
        reset = 1'b0;
        m_clear_all();
    endtask

    task automatic do_erase(input int n, input bit with_expose);
        erase = 1'b1; expose = with_expose; anaBias = with_expose;
        for (int i = 0; i < n; i++) tick();
        erase = 1'b0; expose = 1'b0; anaBias = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m_chg[k] = 0; m_trip[k] = 1'b0;
        end
        m_steps = 0;
    endtask

    task automatic do_expose(input int n, input bit rand_bias, input bit rand_ramp);
        expose = 1'b1;
        for (int i = 0; i < n; i++) begin
            anaBias = rand_bias ? 1'($urandom_range(0, 1)) : 1'b1;
            anaRamp = rand_ramp ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            if (anaBias) m_expose_cycle();
        end
        expose = 1'b0; anaBias = 1'b0; anaRamp = 1'b0;
    endtask

    task automatic check_read(input string tag);
        read = 1'b1; drv_en = 1'b0;
        #1;
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s_pix%0d", tag, k), bus_w[k], 8'(m_pdat[k]));
        read = 1'b0; drv_en = 1'b1;
    endtask

    // n ramp steps; bus = step index or random per pixel; optional read cycles interleaved
    task automatic do_convert(input int n, input bit rand_bus, input bit rand_read);
        for (int j = 0; j < n; j++) begin
            if (rand_read && $urandom_range(0, 15) == 0) begin
                read = 1'b1; drv_en = 1'b0; anaRamp = 1'b1;
                #1;
                for (int k = 0; k < 4; k++)
                    chk($sformatf("midread_pix%0d", k), bus_w[k], 8'(m_pdat[k]));
                tick();
                read = 1'b0; drv_en = 1'b1;
            end
            m_steps++;
            for (int k = 0; k < 4; k++)
                drv[k] = rand_bus ? 8'($urandom_range(0, 255)) : 8'(m_steps);
            anaRamp = 1'b1;
            tick();
            for (int k = 0; k < 4; k++) begin
                if (!m_trip[k]) begin
                    m_pdat[k] = drv[k];
                    if (m_steps > (m_chg[k] >> 8)) m_trip[k] = 1'b1;
                end
            end
        end
        anaRamp = 1'b0;
    endtask

    task automatic check_hiz(input string tag);
        read = 1'b0; drv_en = 1'b1;
        for (int k = 0; k < 4; k++) drv[k] = 8'($urandom_range(0, 255));
        #1;
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s_pix%0d", tag, k), bus_w[k], drv[k]);
    endtask

    initial begin
        logic [7:0] exp_t6;
        for (int k = 0; k < 4; k++) drv[k] = 8'h00;
        m_clear_all();

        // T1: reset, bus released during reset and when not reading
        tick();
        check_hiz("reset_busz");
        do_reset(2);
        check_read("t1_read");
        for (int k = 0; k < 4; k++) chk($sformatf("t1_const_pix%0d", k), bus_w[k], 8'h00);
        check_hiz("t1_busz");

        // T2/T3: full exposure at constant bias then step-index ramp
        do_erase(5, 1'b0);
        do_expose(255, 1'b0, 1'b0);
        do_convert(255, 1'b0, 1'b0);
        check_read("t2_read");
        read = 1'b1; drv_en = 1'b0; #1;
        chk("t3_pix0_64", pixData1, 8'd64);
        chk("t2_pix1_128", pixData2, 8'd128);
        chk("t3_pix2_192", pixData3, 8'd192);
        chk("t3_pix3_255", pixData4, 8'd255);
        read = 1'b0; drv_en = 1'b1;
        check_read("t2_repeat");

        // T4: reset in the middle of a convert
        do_erase(2, 1'b0);
        do_expose(100, 1'b0, 1'b0);
        do_convert(50, 1'b0, 1'b0);
        anaRamp = 1'b1;
        do_reset(1);
        anaRamp = 1'b0;
        check_read("t4_read");

        // T5: erase beats expose
        do_erase(10, 1'b1);
        do_convert(20, 1'b0, 1'b0);
        check_read("t5_read");
        read = 1'b1; drv_en = 1'b0; #1;
        chk("t5_pix3_1", pixData4, 8'd1);
        read = 1'b0; drv_en = 1'b1;

        // T6: long exposure, overflow handling
        do_erase(1, 1'b0);
        do_expose(1024, 1'b0, 1'b0);
        do_convert(255, 1'b0, 1'b0);
        check_read("t6_read");
`ifdef PIXEL_SAT_EN
        exp_t6 = 8'd255;
`else
        exp_t6 = 8'd253;
`endif
        read = 1'b1; drv_en = 1'b0; #1;
        chk("t6_pix3", pixData4, exp_t6);
        read = 1'b0; drv_en = 1'b1;

        // random trials: random bias and ignored ramp pulses during exposure, random bus codes
        for (int t = 0; t < 6; t++) begin
            do_erase($urandom_range(1, 5), 1'($urandom_range(0, 1)));
            do_expose($urandom_range(0, 1100), 1'b1, 1'b1);
            do_convert($urandom_range(1, 255), 1'b1, 1'b1);
            check_read($sformatf("rand%0d", t));
            check_hiz($sformatf("rand%0d_busz", t));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
